pipelined_exec_core: RTL and testbench

PIPELINED_EXEC_CORE -- requirements
Module: pipelined_exec_core

---
 rtl/exec_core_pkg.sv | 108 ++++++++++
 rtl/exec_core_mul.sv | 50 +++++
 rtl/pipelined_exec_core.sv | 149 ++++++++++++++
 tb/tb_pipelined_exec_core.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_core_pkg.sv
// Shared encodings, ALU op codes, multiplier FSM states and stage bundles
// for the pipelined execution core.
package exec_core_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_MUL     = 3'b000;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_MUL
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } mul_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        alu_op_e     op;
        logic        use_imm;
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } id_ex_t;

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic [4:0] rd;
    } ex_wb_t;

    function automatic id_ex_t decode(input if_id_t id, input logic mul_en);
        id_ex_t     d;
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       bad;
        opc   = id.instr[6:0];
        f3    = id.instr[14:12];
        f7    = id.instr[31:25];
        d     = '0;
        bad   = 1'b0;
        d.rd  = id.instr[11:7];
        d.rs1 = id.instr[19:15];
        d.rs2 = id.instr[24:20];
        d.imm = id.instr[31:20];
        unique case (1'b1)
            opc == OPC_OP: begin
                case ({f7, f3})
                    {F7_BASE, F3_ADD}:   d.op = ALU_ADD;
                    {F7_ALT, F3_ADD}:    d.op = ALU_SUB;
                    {F7_BASE, F3_SLL}:   d.op = ALU_SLL;
                    {F7_BASE, F3_XOR}:   d.op = ALU_XOR;
                    {F7_BASE, F3_SRL}:   d.op = ALU_SRL;
                    {F7_BASE, F3_OR}:    d.op = ALU_OR;
                    {F7_BASE, F3_AND}:   d.op = ALU_AND;
                    {F7_MULDIV, F3_MUL}: begin
                        if (mul_en) d.op = ALU_MUL;
                        else        bad  = 1'b1;
                    end
                    default:             bad  = 1'b1;
                endcase
            end
            opc == OPC_OPIMM: begin
                d.use_imm = 1'b1;
                case (f3)
                    F3_ADD:  d.op = ALU_ADD;
                    F3_XOR:  d.op = ALU_XOR;
                    F3_OR:   d.op = ALU_OR;
                    F3_AND:  d.op = ALU_AND;
                    default: bad  = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        d.valid   = id.valid;
        d.illegal = id.valid & bad;
        return d;
    endfunction

endpackage

// File: rtl/exec_core_mul.sv
// Iterative shift-add multiplier: the start edge performs step 0,
// then one step per cycle; done flags the final step.
module exec_core_mul #(
    parameter int XLEN = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == CW'(XLEN - 1));
    assign product = acc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= op_b[0] ? op_a : '0;
            mcand_q  <= op_a << 1;
            mplier_q <= op_b >> 1;
            cnt_q    <= CW'(1);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (done) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/pipelined_exec_core.sv
// ID -> EX -> WB integer core with WB-to-EX forwarding and an iterative
// multiplier that freezes ID/EX while it runs.
import exec_core_pkg::*;

module pipelined_exec_core #(
    parameter int XLEN   = 16,
    parameter int NREGS  = 32,
    parameter int MUL_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    output logic                     wb_valid,
    output logic [$clog2(NREGS)-1:0] wb_rd,
    output logic [XLEN-1:0]          wb_data,
    output logic                     busy,
    output logic                     illegal
);

    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(XLEN);

    mul_state_e      state_q, state_d;
    if_id_t          id_q;
    id_ex_t          ex_q, ex_d;
    ex_wb_t          wb_q;
    logic [XLEN-1:0] wb_data_q;
    logic            run_q;
    logic [XLEN-1:0] regs [NREGS];

    logic            ex_is_mul, mul_start, pipe_hold, take;
    logic            mul_busy, mul_done;
    logic [XLEN-1:0] mul_prod;
    logic [AW-1:0]   ra1, ra2, wa;
    logic            wb_wen, fwd1, fwd2;
    logic [XLEN-1:0] op1, op2, op2_reg, imm_x, alu_res;
    logic [SW-1:0]   shamt;

    assign ex_d      = decode(id_q, MUL_EN != 0);
    assign ex_is_mul = ex_q.valid && (ex_q.op == ALU_MUL);
    assign mul_start = ex_is_mul && (state_q == S_IDLE);
    // The MUL stays in EX from its start cycle until DONE hands it to WB.
    assign pipe_hold = mul_start || (state_q == S_RUN);
    assign in_ready  = run_q && (state_q == S_IDLE) && !mul_start;
    assign take      = in_valid && in_ready;
    assign busy      = mul_busy || (state_q == S_DONE);

    assign ra1     = ex_q.rs1[AW-1:0];
    assign ra2     = ex_q.rs2[AW-1:0];
    assign wa      = wb_q.rd[AW-1:0];
    assign wb_wen  = wb_q.valid && !wb_q.illegal;
    assign fwd1    = wb_wen && (wa == ra1) && (ra1 != '0);
    assign fwd2    = wb_wen && (wa == ra2) && (ra2 != '0);
    assign op1     = fwd1 ? wb_data_q : regs[ra1];
    assign op2_reg = fwd2 ? wb_data_q : regs[ra2];
    assign imm_x   = XLEN'($signed(ex_q.imm));
    assign op2     = ex_q.use_imm ? imm_x : op2_reg;
    assign shamt   = op2[SW-1:0];

    always_comb begin
        alu_res = '0;
        case (ex_q.op)
            ALU_ADD: alu_res = op1 + op2;
            ALU_SUB: alu_res = op1 - op2;
            ALU_AND: alu_res = op1 & op2;
            ALU_OR:  alu_res = op1 | op2;
            ALU_XOR: alu_res = op1 ^ op2;
            ALU_SLL: alu_res = op1 << shamt;
            ALU_SRL: alu_res = op1 >> shamt;
            default: alu_res = '0;
        endcase
    end

    exec_core_mul #(
        .XLEN(XLEN)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .op_a    (op1),
        .op_b    (op2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (mul_start) state_d = S_RUN;
            S_RUN:   if (mul_done)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            run_q     <= 1'b0;
            id_q      <= '0;
            ex_q      <= '0;
            wb_q      <= '0;
            wb_data_q <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (!pipe_hold) begin
                id_q.valid <= take;
                id_q.instr <= take ? in_instr : 32'h0;
                ex_q       <= ex_d;
            end
            unique case (1'b1)
                state_q == S_DONE: begin
                    wb_q.valid   <= 1'b1;
                    wb_q.illegal <= 1'b0;
                    wb_q.rd      <= ex_q.rd;
                    wb_data_q    <= mul_prod;
                end
                pipe_hold: begin
                    wb_q      <= '0;
                    wb_data_q <= '0;
                end
                default: begin
                    wb_q.valid   <= ex_q.valid;
                    wb_q.illegal <= ex_q.illegal;
                    wb_q.rd      <= ex_q.illegal ? 5'd0 : ex_q.rd;
                    wb_data_q    <= ex_q.illegal ? '0 : alu_res;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_wen && (wa != '0)) begin
            regs[wa] <= wb_data_q;
        end
    end

    assign wb_valid = wb_wen;
    assign illegal  = wb_q.valid && wb_q.illegal;
    assign wb_rd    = wa;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_pipelined_exec_core.sv
// Directed bench: program queue driver, WB event log, hand-computed
// expectations for latency, forwarding, MUL timing, illegal ops and reset.
module tb_pipelined_exec_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid, in_ready, wb_valid, busy, illegal;
    logic [31:0] in_instr;
    logic [4:0]  wb_rd;
    logic [15:0] wb_data;
    logic        in_valid2, in_ready2, wb_valid2, busy2, illegal2;
    logic [31:0] in_instr2;
    logic [4:0]  wb_rd2;
    logic [15:0] wb_data2;

    always #5 clk = ~clk;

    pipelined_exec_core #(.XLEN(16), .NREGS(32), .MUL_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .busy(busy), .illegal(illegal)
    );

    pipelined_exec_core #(.XLEN(16), .NREGS(32), .MUL_EN(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_instr(in_instr2), .wb_valid(wb_valid2), .wb_rd(wb_rd2),
        .wb_data(wb_data2), .busy(busy2), .illegal(illegal2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] prog [$];
    int          acc_c [$];
    int          ev_c [$];
    logic [4:0]  ev_rd [$];
    logic [15:0] ev_d [$];
    int          ill_c [$];
    int          busy_n, rdy_busy_n;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] i_op(input logic [2:0] f3, input int rd,
                                         input int rs1, input int imm);
        logic [11:0] im;
        im = imm[11:0];
        return {im, 5'(rs1), f3, 5'(rd), 7'b0010011};
    endfunction

    function automatic logic [31:0] r_op(input logic [6:0] f7,
                                         input logic [2:0] f3, input int rd,
                                         input int rs1, input int rs2);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1,
                                         input int imm);
        return i_op(3'b000, rd, rs1, imm);
    endfunction

    function automatic logic [31:0] add(input int rd, input int a, input int b);
        return r_op(7'b0000000, 3'b000, rd, a, b);
    endfunction

    function automatic logic [31:0] sub(input int rd, input int a, input int b);
        return r_op(7'b0100000, 3'b000, rd, a, b);
    endfunction

    function automatic logic [31:0] mul(input int rd, input int a, input int b);
        return r_op(7'b0000001, 3'b000, rd, a, b);
    endfunction

    task automatic clear();
        prog.delete();
        acc_c.delete();
        ev_c.delete();
        ev_rd.delete();
        ev_d.delete();
        ill_c.delete();
        busy_n     = 0;
        rdy_busy_n = 0;
    endtask

    task automatic run(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            logic take;
            in_valid = (prog.size() != 0);
            in_instr = in_valid ? prog[0] : 32'h0;
            #1;
            take = in_valid && in_ready;
            if (busy) busy_n++;
            if (busy && in_ready) rdy_busy_n++;
            step();
            if (take) begin
                void'(prog.pop_front());
                acc_c.push_back(c);
            end
            if (wb_valid) begin
                ev_c.push_back(c);
                ev_rd.push_back(wb_rd);
                ev_d.push_back(wb_data);
            end
            if (illegal) ill_c.push_back(c);
        end
        in_valid = 1'b0;
        in_instr = 32'h0;
    endtask

    task automatic ev(input string tag, input int idx, input int cyc,
                      input int rd, input int data);
        if (idx < ev_c.size()) begin
            chk({tag, ".cyc"}, 32'(ev_c[idx]), 32'(cyc));
            chk({tag, ".rd"}, 32'(ev_rd[idx]), 32'(rd));
            chk({tag, ".data"}, 32'(ev_d[idx]), 32'(data));
        end else begin
            chk({tag, ".present"}, 32'(ev_c.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        logic [31:0] lw_instr;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_valid2 = 1'b0;
        in_instr2 = 32'h0;
        clear();

        repeat (3) step();
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.wb_valid", 32'(wb_valid), 32'd0);
        chk("rst.wb_rd", 32'(wb_rd), 32'd0);
        chk("rst.wb_data", 32'(wb_data), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.illegal", 32'(illegal), 32'd0);

        rst = 1'b1;
        #1;
        chk("rel.ready_before_edge", 32'(in_ready), 32'd0);
        step();
        chk("rel.ready_after_edge", 32'(in_ready), 32'd1);
        chk("rel.ready2", 32'(in_ready2), 32'd1);

        // MUL on a core built without the multiplier
        in_valid2 = 1'b1;
        in_instr2 = mul(5, 1, 2);
        step();
        in_valid2 = 1'b0;
        step();
        step();
        chk("nomul.illegal", 32'(illegal2), 32'd1);
        chk("nomul.wb_valid", 32'(wb_valid2), 32'd0);
        chk("nomul.busy", 32'(busy2), 32'd0);
        step();
        chk("nomul.pulse_end", 32'(illegal2), 32'd0);

        clear();
        prog.push_back(addi(1, 0, 5));
        prog.push_back(addi(2, 0, -3));
        run(6);
        chk("addi.count", 32'(ev_c.size()), 32'd2);
        ev("addi.x1", 0, 2, 1, 16'h0005);
        ev("addi.x2", 1, 3, 2, 16'hFFFD);

        clear();
        prog.push_back(addi(3, 0, 7));
        prog.push_back(add(4, 3, 3));
        prog.push_back(addi(7, 0, 1));
        prog.push_back(sub(8, 3, 7));
        prog.push_back(add(11, 4, 8));
        run(9);
        chk("fwd.count", 32'(ev_c.size()), 32'd5);
        chk("fwd.no_stall", 32'(acc_c[4]), 32'd4);
        ev("fwd.x3", 0, 2, 3, 7);
        ev("fwd.x4", 1, 3, 4, 14);
        ev("fwd.x8", 3, 5, 8, 6);
        ev("fwd.x11", 4, 6, 11, 20);

        clear();
        prog.push_back(addi(1, 0, 300));
        prog.push_back(addi(2, 0, 200));
        prog.push_back(mul(5, 1, 2));
        prog.push_back(add(9, 5, 1));
        prog.push_back(addi(10, 0, 1));
        run(28);
        chk("mul.busy_cycles", 32'(busy_n), 32'd16);
        chk("mul.ready_while_busy", 32'(rdy_busy_n), 32'd0);
        chk("mul.accepts", 32'(acc_c.size()), 32'd5);
        chk("mul.shadow_accept", 32'(acc_c[3]), 32'd3);
        chk("mul.held_accept", 32'(acc_c[4]), 32'd21);
        chk("mul.count", 32'(ev_c.size()), 32'd5);
        ev("mul.x5", 2, 20, 5, 16'hEA60);
        ev("mul.x9", 3, 21, 9, 16'hEB8C);
        ev("mul.x10", 4, 23, 10, 1);

        clear();
        prog.push_back(addi(0, 0, 9));
        prog.push_back(add(6, 0, 0));
        run(6);
        chk("x0.count", 32'(ev_c.size()), 32'd2);
        ev("x0.x6", 1, 3, 6, 0);
        if (ev_c.size() > 0) chk("x0.rd", 32'(ev_rd[0]), 32'd0);

        clear();
        lw_instr = 32'h0000_2083;
        prog.push_back(lw_instr);
        prog.push_back(i_op(3'b001, 1, 1, 1));
        prog.push_back(addi(12, 0, 3));
        prog.push_back(add(13, 1, 0));
        run(9);
        chk("ill.count", 32'(ill_c.size()), 32'd2);
        if (ill_c.size() > 1) begin
            chk("ill.cyc0", 32'(ill_c[0]), 32'd2);
            chk("ill.cyc1", 32'(ill_c[1]), 32'd3);
        end
        chk("ill.wb_count", 32'(ev_c.size()), 32'd2);
        ev("ill.x12", 0, 4, 12, 3);
        ev("ill.x13", 1, 5, 13, 300);

        clear();
        prog.push_back(mul(5, 1, 2));
        run(5);
        chk("abort.busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.in_ready", 32'(in_ready), 32'd0);
        chk("abort.wb_valid", 32'(wb_valid), 32'd0);
        chk("abort.wb_rd", 32'(wb_rd), 32'd0);
        chk("abort.wb_data", 32'(wb_data), 32'd0);
        chk("abort.illegal", 32'(illegal), 32'd0);
        repeat (2) step();
        rst = 1'b1;
        clear();
        run(25);
        chk("abort.no_wb", 32'(ev_c.size()), 32'd0);
        chk("abort.busy_after", 32'(busy_n), 32'd0);
        clear();
        prog.push_back(add(14, 1, 2));
        run(5);
        ev("abort.regs_cleared", 0, 2, 14, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
